noise_burst_scheduler: RTL and testbench
========================================

# noise_burst_scheduler

Programmable burst controller that generates the `enable` gate for the background noise generator. It sits directly upstream of that stage. On a start request it drives a registered enable high for a configured number of on-cycles, then low for off-cycles, repeating for a configured burst count or continuously. It also reports progress and completion to the controlling logic.

## Interface

Parameters:
- `CNT_W`, 16: width of the on/off period fields and their internal down-counter.
- `BURST_W`, 8: width of the burst-count field and the `bursts_done` counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `start`  in  1  start request; sampled only in IDLE.
- `abort`  in  1  stop request; acts in any state.
- `on_cycles`  in  CNT_W  enable-high length per burst; latched at start.
- `off_cycles`  in  CNT_W  enable-low gap between bursts; latched at start.
- `num_bursts`  in  BURST_W  bursts to run, latched at start; 0 = continuous until abort.
- `enable_out`  out  1  registered gate; connects to the noise generator `enable`.
- `busy`  out  1  high in ON and OFF.
- `done`  out  1  one-cycle pulse after the final burst of a finite run.
- `aborted`  out  1  one-cycle pulse when a run is terminated by `abort`.
- `bursts_done`  out  BURST_W  completed bursts in the current or last run.

## Operation

States are IDLE, ON, OFF and DONE.

- **Reset:** state = IDLE. `enable_out`, `busy`, `done`, `aborted`, `bursts_done`, the counters and the latched config all = 0.
- **IDLE:**
  - `start`=1 and `abort`=0: latch the config, clear `bursts_done`, load the ON counter, go to ON.
  - Otherwise stay in IDLE. Any input combination with `abort`=1 stays in IDLE with no pulses.
- **Effective on-length:** max(`on_cycles`, 1). An `on_cycles` of 0 is treated as 1.
- **ON:**
  - `enable_out`=1 and `busy`=1. Count down the effective on-length.
  - On the last ON cycle, `bursts_done` increments. It wraps modulo 2^BURST_W, which only occurs in continuous mode.
  - If the burst just finished equals `num_bursts` (and `num_bursts` ≠ 0), go to DONE.
  - Else if latched `off_cycles` = 0, reload ON (back-to-back bursts; `enable_out` stays high).
  - Else go to OFF.
- **OFF:** `enable_out`=0 and `busy`=1 for exactly `off_cycles` cycles, then go to ON.
- **DONE:** lasts one cycle with `done`=1, `busy`=0 and `enable_out`=0, then go to IDLE. `start` in DONE is ignored.
- **Abort:** `abort`=1 in ON or OFF moves the block to IDLE on the next edge. That cycle clears `enable_out`, drops `busy` and pulses `aborted` for 1 cycle. `bursts_done` holds the count completed so far.
- **Abort in DONE:** the run has already completed. `done` still pulses and `aborted` stays 0.
- **Simultaneous abort and final ON cycle:** abort wins. `aborted` pulses, `done` does not, and `bursts_done` is not incremented.
- **Config inputs:** changes while `busy` have no effect until the next start.

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- **Start latency:** `start` sampled at edge t; `enable_out`=1 and `busy`=1 from the cycle after t.
- **Burst shape:** `enable_out` is high for exactly max(`on_cycles`,1) consecutive cycles per burst, then low for exactly `off_cycles` cycles.
- **Finite-run length:** total cycles with `busy`=1 = N·on + (N−1)·off, where N = `num_bursts`.
- **End of run:** `done` asserts in the cycle immediately after the last `enable_out`=1 cycle.
- **Restart:** the earliest next `start` is accepted in the cycle after `done`, once the state is back in IDLE.
- **Abort latency:** `enable_out` low in the cycle after `abort` is sampled.
- **Mid-run reset:** `rst` asserted mid-run forces `enable_out` low immediately, without waiting for a clock edge.

## Test plan

- **Reset values:** assert `rst` mid-ON burst → `enable_out`=0 asynchronously; after release all outputs are 0 and the block ignores inputs until `start`.
- **Finite run:** `on`=4, `off`=3, `num_bursts`=3, pulse `start` → `enable_out` pattern 1111 000 1111 000 1111, `busy` high for 18 cycles, `done` high 1 cycle after the last 1, `bursts_done`=3.
- **Zero-length fields:** `on`=0, `off`=0, `num_bursts`=2 → `enable_out` high for 2 cycles (1+1 back-to-back), then `done`; `bursts_done`=2.
- **Continuous mode with abort:** `num_bursts`=0, `on`=2, `off`=1; abort after 300 bursts → `bursts_done`=300 mod 256 = 44, `aborted` pulses, `done` never asserts, `enable_out`=0 on the next cycle.
- **Simultaneous events:**
  - `start`+`abort` in IDLE → no run begins.
  - `abort` on the final ON cycle → `aborted`=1, `done`=0, `bursts_done`=N−1.
  - `start` during DONE → ignored.
- **Config isolation:** change `on_cycles` from 5 to 9 while `busy` → all bursts of the run stay 5 cycles; the next `start` uses 9.

Source files
------------

// File: rtl/noise_burst_scheduler.sv
// Burst gate for the background noise generator: on/off periods,
// finite or continuous burst count, with done/abort reporting.
module noise_burst_scheduler #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   on_cycles,
  input  logic [CNT_W-1:0]   off_cycles,
  input  logic [BURST_W-1:0] num_bursts,
  output logic               enable_out,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [BURST_W-1:0] bursts_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   on_rl, off_q, on_load;
  logic [BURST_W-1:0] nb_q, bd_n, bd_inc;
  logic               abort_evt, cfg_ld;

  // Counter holds remaining cycles minus one; on length 0 acts as 1.
  assign on_load = (on_cycles == '0) ? '0 : on_cycles - 1'b1;
  assign bd_inc  = bursts_done + 1'b1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bd_n      = bursts_done;
    abort_evt = 1'b0;
    cfg_ld    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n = S_ON;
          cnt_n   = on_load;
          bd_n    = '0;
          cfg_ld  = 1'b1;
        end
      end
      S_ON: begin
        if (abort) begin
          state_n   = S_IDLE;
          abort_evt = 1'b1;
        end else if (cnt == '0) begin
          bd_n = bd_inc;
          if (nb_q != '0 && bd_inc == nb_q) begin
            state_n = S_DONE;
          end else if (off_q == '0) begin
            cnt_n = on_rl;
          end else begin
            state_n = S_OFF;
            cnt_n   = off_q - 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_OFF: begin
        if (abort) begin
          state_n   = S_IDLE;
          abort_evt = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_ON;
          cnt_n   = on_rl;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      on_rl       <= '0;
      off_q       <= '0;
      nb_q        <= '0;
      bursts_done <= '0;
      enable_out  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bursts_done <= bd_n;
      if (cfg_ld) begin
        on_rl <= on_load;
        off_q <= off_cycles;
        nb_q  <= num_bursts;
      end
      enable_out <= (state_n == S_ON);
      busy       <= (state_n == S_ON) || (state_n == S_OFF);
      done       <= (state_n == S_DONE);
      aborted    <= abort_evt;
    end
  end

endmodule

// File: tb/tb_noise_burst_scheduler.sv
// Scoreboard bench: expected enable runs and done/abort events are
// queued by stimulus and popped by an independent output monitor.
module tb_noise_burst_scheduler;

  localparam int K_RUN   = 0;
  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] on_cycles = '0;
  logic [15:0] off_cycles = '0;
  logic [7:0]  num_bursts = '0;
  logic        enable_out, busy, done, aborted;
  logic [7:0]  bursts_done;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;

  noise_burst_scheduler #(.CNT_W(16), .BURST_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .on_cycles(on_cycles),
    .off_cycles(off_cycles),
    .num_bursts(num_bursts),
    .enable_out(enable_out),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .bursts_done(bursts_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    q.push_back(e);
  endtask

  task automatic obs(input int kind, input int a, input int b);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event kind=%0d val=%0d want=none", kind, a);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_val", a, e.a);
      if (e.kind == K_DONE) check("busy_cycles", b, e.b);
    end
  endtask

  // Monitor: enable run lengths, done/aborted pulses, busy totals.
  initial begin
    int  run;
    int  busy_cnt;
    bit  prev_en;
    run = 0;
    busy_cnt = 0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
        busy_cnt = 0;
        prev_en = 1'b0;
      end else begin
        if (enable_out) run++;
        else if (prev_en) begin
          obs(K_RUN, run, 0);
          run = 0;
        end
        if (busy) busy_cnt++;
        if (done) begin
          obs(K_DONE, bursts_done, busy_cnt);
          busy_cnt = 0;
        end
        if (aborted) begin
          obs(K_ABORT, bursts_done, 0);
          busy_cnt = 0;
        end
        prev_en = enable_out;
      end
    end
  end

  task automatic launch(input int on, input int off, input int nb);
    @(posedge clk);
    #1;
    on_cycles = 16'(on);
    off_cycles = 16'(off);
    num_bursts = 8'(nb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_enable", enable_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_bursts", bursts_done, 0);
    #12 rst = 1'b0;

    // asynchronous reset in the middle of an ON burst
    launch(10, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_enable", enable_out, 1);
    rst = 1'b1;
    #1;
    check("async_rst_enable", enable_out, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    abort = 1'b1;
    on_cycles = 16'd3;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_enable", enable_out, 0);
    check("idle_bursts", bursts_done, 0);
    abort = 1'b0;

    // start together with abort in IDLE
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("start_abort_busy", busy, 0);
    check("start_abort_enable", enable_out, 0);

    // finite run 4/3 x3
    for (int i = 0; i < 3; i++) push(K_RUN, 4, 0);
    push(K_DONE, 3, 18);
    launch(4, 3, 3);
    drain(40);
    check("finite_bursts", bursts_done, 3);

    // zero-length fields: back-to-back single-cycle bursts
    push(K_RUN, 2, 0);
    push(K_DONE, 2, 2);
    launch(0, 0, 2);
    drain(20);

    // start and abort during DONE are ignored
    push(K_RUN, 1, 0);
    push(K_DONE, 1, 1);
    launch(1, 1, 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    drain(10);
    check("done_start_ignored", busy, 0);

    // abort on the final ON cycle of a 3/2 x2 run
    push(K_RUN, 3, 0);
    push(K_RUN, 3, 0);
    push(K_ABORT, 1, 0);
    launch(3, 2, 2);
    repeat (7) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("final_abort_enable", enable_out, 0);
    check("final_abort_pulse", aborted, 1);
    check("final_abort_done", done, 0);
    drain(10);
    check("final_abort_bursts", bursts_done, 1);

    // config changes while busy are ignored
    push(K_RUN, 5, 0);
    push(K_RUN, 5, 0);
    push(K_DONE, 2, 12);
    launch(5, 2, 2);
    repeat (3) @(posedge clk);
    #1;
    on_cycles = 16'd9;
    off_cycles = 16'd7;
    num_bursts = 8'd1;
    drain(40);
    push(K_RUN, 9, 0);
    push(K_DONE, 1, 9);
    launch(9, 7, 1);
    drain(30);

    // continuous mode, abort in the gap after burst 300
    for (int i = 0; i < 300; i++) push(K_RUN, 2, 0);
    push(K_ABORT, 44, 0);
    launch(2, 1, 0);
    repeat (899) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("cont_enable", enable_out, 0);
    check("cont_bursts", bursts_done, 44);
    drain(10);
    check("cont_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
